// File: rtl/psum_accum_unit.sv
`default_nettype none
// ============================================================================
// psum_accum_unit : pops partial-sum vectors, optionally accumulates them with
// psum memory, applies saturation (macro PSUM_SAT_EN) / ReLU and writes back.
// Revision : 1.0
// ============================================================================
module psum_accum_unit #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     acc_i,
    input  logic                     relu_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    input  logic [CNT_W-1:0]         vec_cnt_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic [COL*PSUM_BW-1:0]   ofifo_out_i,
    input  logic                     ofifo_valid_i,
    output logic                     ofifo_rd_o,
    output logic                     psum_mem_rd_o,
    output logic [ADDR_W-1:0]        psum_mem_raddr_o,
    input  logic [COL*PSUM_BW-1:0]   psum_mem_dout_i,
    output logic                     psum_mem_wr_o,
    output logic [ADDR_W-1:0]        psum_mem_waddr_o,
`ifdef PSUM_SAT_EN
    output logic                     sat_flag_o,
`endif
    output logic [COL*PSUM_BW-1:0]   psum_mem_din_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   acc_q;
    logic                   relu_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic [CNT_W-1:0]       remaining_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   s1_valid_q;
    logic [COL*PSUM_BW-1:0] s1_data_q;
    logic [ADDR_W-1:0]      s1_addr_q;

    logic                   wr_q;
    logic [ADDR_W-1:0]      waddr_q;
    logic [COL*PSUM_BW-1:0] din_q;
    logic [COL*PSUM_BW-1:0] result_d;

    logic                   issue;
    logic                   start_ok;

    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_ok = 1'b1;
                    state_d  = (vec_cnt_i == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                issue = ofifo_valid_i && (remaining_q != '0);
                if (issue && (remaining_q == CNT_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            // Stage 1 hands its last vector to stage 2 on this edge; FIN then
            // covers the final write and done follows once that write is out.
            S_DRAIN: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            acc_q       <= 1'b0;
            relu_q      <= 1'b0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_FIN);
            busy_q  <= (state_d != S_IDLE) || (state_q == S_FIN);
            if (start_ok) begin
                acc_q       <= acc_i;
                relu_q      <= relu_i;
                rd_addr_q   <= base_addr_i;
                remaining_q <= vec_cnt_i;
            end else if (issue) begin
                rd_addr_q   <= rd_addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_addr_q  <= '0;
        end else begin
            s1_valid_q <= issue;
            if (issue) begin
                s1_data_q <= ofifo_out_i;
                s1_addr_q <= rd_addr_q;
            end
        end
    end

`ifdef PSUM_SAT_EN
    logic [COL-1:0] lane_clamp;
`endif

    // Memory read data arrives in the same cycle the vector sits in stage 1.
    generate
        for (genvar g = 0; g < COL; g++) begin : g_lane
            logic signed [PSUM_BW-1:0] s1_lane;
            logic signed [PSUM_BW-1:0] mem_lane;
            logic signed [PSUM_BW-1:0] lane_nar;

            assign s1_lane  = s1_data_q[g*PSUM_BW +: PSUM_BW];
            assign mem_lane = acc_q ? psum_mem_dout_i[g*PSUM_BW +: PSUM_BW] : '0;
`ifdef PSUM_SAT_EN
            logic signed [PSUM_BW:0] lane_sum;
            assign lane_sum      = {s1_lane[PSUM_BW-1], s1_lane}
                                 + {mem_lane[PSUM_BW-1], mem_lane};
            assign lane_clamp[g] = lane_sum[PSUM_BW] ^ lane_sum[PSUM_BW-1];
            assign lane_nar      = !lane_clamp[g]    ? lane_sum[PSUM_BW-1:0] :
                                   lane_sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} :
                                                       {1'b0, {(PSUM_BW-1){1'b1}}};
`else
            assign lane_nar = s1_lane + mem_lane;
`endif
            assign result_d[g*PSUM_BW +: PSUM_BW] =
                (relu_q && lane_nar[PSUM_BW-1]) ? '0 : lane_nar;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q    <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
        end else begin
            wr_q <= s1_valid_q;
            if (s1_valid_q) begin
                waddr_q <= s1_addr_q;
                din_q   <= result_d;
            end
        end
    end

`ifdef PSUM_SAT_EN
    logic sat_flag_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sat_flag_q <= 1'b0;
        end else if (start_ok) begin
            sat_flag_q <= 1'b0;
        end else if (s1_valid_q && (lane_clamp != '0)) begin
            sat_flag_q <= 1'b1;
        end
    end

    assign sat_flag_o = sat_flag_q;
`endif

    assign ofifo_rd_o       = issue;
    assign psum_mem_rd_o    = issue && acc_q;
    assign psum_mem_raddr_o = rd_addr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign psum_mem_wr_o    = wr_q;
    assign psum_mem_waddr_o = waddr_q;
    assign psum_mem_din_o   = din_q;

endmodule
`default_nettype wire
